amacv2_axil_regbank: RTL and testbench



---
 rtl/amacv2_axil_pkg.sv | 24 ++
 rtl/amacv2_axil_regbank_if.sv | 40 ++++
 rtl/amacv2_axil_wr_fsm.sv | 112 +++++++++++
 rtl/amacv2_axil_regbank.sv | 162 ++++++++++++++++
 tb/tb_amacv2_axil_regbank.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/amacv2_axil_pkg.sv
// Shared types for the AMACv2 AXI4-Lite register bank: response codes, FSM
// state encodings and the byte-address to word-index helper.
package amacv2_axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef logic [0:0] wr_state_t;
    typedef logic [0:0] rd_state_t;

    localparam wr_state_t W_IDLE = 1'b0;
    localparam wr_state_t W_RESP = 1'b1;
    localparam rd_state_t R_IDLE = 1'b0;
    localparam rd_state_t R_DATA = 1'b1;

    // The two low address bits select a byte within a word and are dropped.
    function automatic int word_idx(input logic [31:0] addr);
        return int'(addr >> 2);
    endfunction

endpackage

// File: rtl/amacv2_axil_regbank_if.sv
// AXI4-Lite slave channel bundle; the master modport belongs to the
// interconnect side, the slave modport to the register bank.
interface amacv2_axil_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    // Every channel transfers on the rising edge where VALID and READY are
    // both high; a source holds VALID and its payload stable until then.
    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/amacv2_axil_wr_fsm.sv
// Write path: independent AW/W capture, commit once both are held, then hold
// the B response until the master accepts it.
module amacv2_axil_wr_fsm
    import amacv2_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CTRL   = 8,
    parameter int NUM_STAT   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic                  commit_o,
    output logic [ADDR_WIDTH-3:0] commit_idx_o,
    output logic [31:0]           commit_data_o,
    output logic [3:0]            commit_strb_o,
    output wr_state_t             state_o
);

    wr_state_t             state_q, state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [3:0]            strb_q, strb_d;
    logic                  bvalid_q, bvalid_d;
    resp_t                 bresp_q, bresp_d;
    int                    aw_word;

    assign awready_o     = !rst_i && (state_q == W_IDLE) && !aw_held_q;
    assign wready_o      = !rst_i && (state_q == W_IDLE) && !w_held_q;
    assign commit_o      = (state_q == W_IDLE) && aw_held_q && w_held_q;
    assign commit_idx_o  = addr_q[ADDR_WIDTH-1:2];
    assign commit_data_o = data_q;
    assign commit_strb_o = strb_q;
    assign bvalid_o      = bvalid_q;
    assign bresp_o       = bresp_q;
    assign state_o       = state_q;

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        aw_word   = word_idx(32'(addr_q));
        case (state_q)
            W_IDLE: begin
                if (awvalid_i && awready_o) begin
                    aw_held_d = 1'b1;
                    addr_d    = awaddr_i;
                end
                if (wvalid_i && wready_o) begin
                    w_held_d = 1'b1;
                    data_d   = wdata_i;
                    strb_d   = wstrb_i;
                end
                if (commit_o) begin
                    bvalid_d = 1'b1;
                    state_d  = W_RESP;
                    if (aw_word < NUM_CTRL)                 bresp_d = OKAY;
                    else if (aw_word < NUM_CTRL + NUM_STAT) bresp_d = SLVERR;
                    else                                    bresp_d = DECERR;
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    state_d   = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

endmodule

// File: rtl/amacv2_axil_regbank.sv
// AMACv2 tester register bank: RW control words driven to fabric, RO status
// words sampled from fabric, behind an AXI4-Lite slave port.
module amacv2_axil_regbank
    import amacv2_axil_pkg::*;
#(
    parameter int                     DATA_WIDTH = 32,
    parameter int                     ADDR_WIDTH = 8,
    parameter int                     NUM_CTRL   = 8,
    parameter int                     NUM_STAT   = 4,
    parameter logic [NUM_CTRL*32-1:0] CTRL_RESET = '0
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    amacv2_axil_if.slave           s_axi,
    output logic [NUM_CTRL*32-1:0] ctrl_o,
    output logic [NUM_CTRL-1:0]    ctrl_wr_o,
    input  logic [NUM_STAT*32-1:0] stat_i,
    output logic [NUM_STAT-1:0]    stat_rd_o,
    output wr_state_t              wr_state_o,
    output rd_state_t              rd_state_o
);

    logic                   commit;
    logic [ADDR_WIDTH-3:0]  commit_idx;
    logic [31:0]            commit_data;
    logic [3:0]             commit_strb;

    logic [NUM_CTRL*32-1:0] ctrl_q, ctrl_d;
    logic [NUM_CTRL-1:0]    ctrl_wr_q, ctrl_wr_d;

    rd_state_t              rd_state_q, rd_state_d;
    logic                   rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    resp_t                  rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]  mux_data;
    resp_t                  mux_resp;
    logic [ADDR_WIDTH-1:0]  araddr;
    logic                   ar_hs;
    int                     ar_word;

    amacv2_axil_wr_fsm #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_CTRL  (NUM_CTRL),
        .NUM_STAT  (NUM_STAT)
    ) u_wr_fsm (
        .clk_i        (ACLK),
        .rst_i        (ARESET),
        .awaddr_i     (s_axi.S_AXI_AWADDR),
        .awvalid_i    (s_axi.S_AXI_AWVALID),
        .awready_o    (s_axi.S_AXI_AWREADY),
        .wdata_i      (s_axi.S_AXI_WDATA),
        .wstrb_i      (s_axi.S_AXI_WSTRB),
        .wvalid_i     (s_axi.S_AXI_WVALID),
        .wready_o     (s_axi.S_AXI_WREADY),
        .bresp_o      (s_axi.S_AXI_BRESP),
        .bvalid_o     (s_axi.S_AXI_BVALID),
        .bready_i     (s_axi.S_AXI_BREADY),
        .commit_o     (commit),
        .commit_idx_o (commit_idx),
        .commit_data_o(commit_data),
        .commit_strb_o(commit_strb),
        .state_o      (wr_state_o)
    );

    // Only control words match here, so status and unmapped writes fall through.
    always_comb begin
        ctrl_d    = ctrl_q;
        ctrl_wr_d = '0;
        if (commit) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (int'(commit_idx) == k) begin
                    ctrl_wr_d[k] = 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        if (commit_strb[b]) ctrl_d[k*32+b*8 +: 8] = commit_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ctrl_q    <= CTRL_RESET;
            ctrl_wr_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            ctrl_wr_q <= ctrl_wr_d;
        end
    end

    assign ctrl_o    = ctrl_q;
    assign ctrl_wr_o = ctrl_wr_q;

    assign araddr              = s_axi.S_AXI_ARADDR;
    assign s_axi.S_AXI_ARREADY = !ARESET && (rd_state_q == R_IDLE);
    assign ar_hs               = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;

    // Reads sample ctrl_q before any same-edge write lands.
    always_comb begin
        mux_data  = '0;
        mux_resp  = DECERR;
        stat_rd_o = '0;
        ar_word   = word_idx(32'(araddr));
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (ar_word == k) begin
                mux_data = ctrl_q[k*32 +: 32];
                mux_resp = OKAY;
            end
        end
        for (int j = 0; j < NUM_STAT; j++) begin
            if (ar_word == NUM_CTRL + j) begin
                mux_data     = stat_i[j*32 +: 32];
                mux_resp     = OKAY;
                stat_rd_o[j] = ar_hs;
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d    = mux_data;
                    rresp_d    = mux_resp;
                    rvalid_d   = 1'b1;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axi.S_AXI_RVALID = rvalid_q;
    assign s_axi.S_AXI_RDATA  = rdata_q;
    assign s_axi.S_AXI_RRESP  = rresp_q;
    assign rd_state_o         = rd_state_q;

endmodule

// File: tb/tb_amacv2_axil_regbank.sv
// Directed bench for amacv2_axil_regbank: stimulus tasks push expected B/R
// responses into queues that a negedge monitor pops and compares.
module tb_amacv2_axil_regbank;

    localparam logic [255:0] CRST = {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004,
                                     32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [255:0] ctrl;
    logic [7:0]   ctrl_wr;
    logic [127:0] stat;
    logic [3:0]   stat_rd;
    logic [0:0]   wr_state;
    logic [0:0]   rd_state;

    int           total = 0;
    int           bad = 0;
    logic [1:0]   exp_b_q[$];
    logic [33:0]  exp_r_q[$];
    int           wr_cnt[8];
    int           rd_cnt[4];
    logic [255:0] crst_v;
    logic [255:0] exp_v;

    always #5 ACLK = ~ACLK;

    amacv2_axil_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) axi ();

    amacv2_axil_regbank #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_CTRL(8), .NUM_STAT(4), .CTRL_RESET(CRST)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .s_axi     (axi.slave),
        .ctrl_o    (ctrl),
        .ctrl_wr_o (ctrl_wr),
        .stat_i    (stat),
        .stat_rd_o (stat_rd),
        .wr_state_o(wr_state),
        .rd_state_o(rd_state)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor and access-pulse counters.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
                if (exp_b_q.size() == 0) chk("b_unexpected", 1, 0);
                else chk("bresp", axi.S_AXI_BRESP, exp_b_q.pop_front());
            end
            if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
                if (exp_r_q.size() == 0) chk("r_unexpected", 1, 0);
                else chk("rresp_rdata", {axi.S_AXI_RRESP, axi.S_AXI_RDATA}, exp_r_q.pop_front());
            end
        end
        for (int k = 0; k < 8; k++) if (ctrl_wr[k]) wr_cnt[k]++;
        for (int j = 0; j < 4; j++) if (stat_rd[j]) rd_cnt[j]++;
    end

    task automatic aw_send(input logic [7:0] addr);
        int n = 0;
        axi.S_AXI_AWADDR  = addr;
        axi.S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        while (!axi.S_AXI_AWREADY && n < 50) begin n++; @(negedge ACLK); end
        if (n >= 50) chk("aw_timeout", 1, 0);
        @(posedge ACLK); #1;
        axi.S_AXI_AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        axi.S_AXI_WDATA  = data;
        axi.S_AXI_WSTRB  = strb;
        axi.S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        while (!axi.S_AXI_WREADY && n < 50) begin n++; @(negedge ACLK); end
        if (n >= 50) chk("w_timeout", 1, 0);
        @(posedge ACLK); #1;
        axi.S_AXI_WVALID = 1'b0;
    endtask

    task automatic ar_send(input logic [7:0] addr);
        int n = 0;
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        while (!axi.S_AXI_ARREADY && n < 50) begin n++; @(negedge ACLK); end
        if (n >= 50) chk("ar_timeout", 1, 0);
        @(posedge ACLK); #1;
        axi.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        @(negedge ACLK);
        while (!axi.S_AXI_BVALID && n < 50) begin n++; @(negedge ACLK); end
        if (n >= 50) chk("b_timeout", 1, 0);
        @(posedge ACLK); #1;
    endtask

    task automatic wait_r();
        int n = 0;
        @(negedge ACLK);
        while (!axi.S_AXI_RVALID && n < 50) begin n++; @(negedge ACLK); end
        if (n >= 50) chk("r_timeout", 1, 0);
        @(posedge ACLK); #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input logic [1:0] resp);
        exp_b_q.push_back(resp);
        fork
            aw_send(addr);
            w_send(data, strb);
        join
        wait_b();
    endtask

    task automatic wr_split(input logic [7:0] addr, input logic [31:0] data, input bit w_first);
        exp_b_q.push_back(2'b00);
        fork
            begin
                if (!w_first) begin repeat (3) @(posedge ACLK); #1; end
                w_send(data, 4'hF);
            end
            begin
                if (w_first) begin repeat (3) @(posedge ACLK); #1; end
                aw_send(addr);
            end
        join
        chk("bvalid_before_commit", axi.S_AXI_BVALID, 0);
        @(posedge ACLK); #1;
        chk("bvalid_after_commit", axi.S_AXI_BVALID, 1);
        wait_b();
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] resp);
        exp_r_q.push_back({resp, data});
        ar_send(addr);
        wait_r();
    endtask

    initial begin
        crst_v = CRST;
        axi.S_AXI_AWADDR  = '0;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA   = '0;
        axi.S_AXI_WSTRB   = '0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_BREADY  = 1'b1;
        axi.S_AXI_ARADDR  = '0;
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY  = 1'b1;
        stat = {32'h44440003, 32'h33330002, 32'h22220001, 32'hCAFEF00D};

        // Reset state
        repeat (3) @(posedge ACLK); #1;
        chk("rst_awready", axi.S_AXI_AWREADY, 0);
        chk("rst_wready", axi.S_AXI_WREADY, 0);
        chk("rst_arready", axi.S_AXI_ARREADY, 0);
        chk("rst_bvalid", axi.S_AXI_BVALID, 0);
        chk("rst_rvalid", axi.S_AXI_RVALID, 0);
        chk("rst_rdata", axi.S_AXI_RDATA, 0);
        chk("rst_ctrl", ctrl, crst_v);
        chk("rst_pulses", {ctrl_wr, stat_rd}, 0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        chk("post_rst_ready", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b111);

        for (int k = 0; k < 8; k++) rd(8'(k * 4), crst_v[k*32 +: 32], 2'b00);

        // Same-cycle AW/W writes
        for (int k = 0; k < 4; k++) wr(8'(k * 4), 32'h11 * (k + 1), 4'hF, 2'b00);
        for (int k = 0; k < 4; k++) rd(8'(k * 4), 32'h11 * (k + 1), 2'b00);
        for (int k = 0; k < 8; k++) chk($sformatf("wr_pulse_cnt%0d", k), wr_cnt[k], (k < 4) ? 1 : 0);

        // Decoupled AW/W ordering
        wr_split(8'h10, 32'hA5A50004, 1'b1);
        wr_split(8'h14, 32'h5A5A0005, 1'b0);
        rd(8'h10, 32'hA5A50004, 2'b00);
        rd(8'h14, 32'h5A5A0005, 2'b00);
        chk("split_pulses", {wr_cnt[4], wr_cnt[5]}, {32'd1, 32'd1});

        // Byte strobes
        wr(8'h00, 32'hFFFFFFFF, 4'hF, 2'b00);
        wr(8'h00, 32'h12345678, 4'b0101, 2'b00);
        rd(8'h00, 32'hFF34FF78, 2'b00);
        wr(8'h00, 32'h00000000, 4'b0000, 2'b00);
        rd(8'h00, 32'hFF34FF78, 2'b00);
        chk("strb0_pulse_cnt", wr_cnt[0], 4);

        // Status / unmapped decode
        wr(8'h20, 32'h0BADBEEF, 4'hF, 2'b10);
        wr(8'h40, 32'h0BADBEEF, 4'hF, 2'b11);
        wr(8'h30, 32'h0BADBEEF, 4'hF, 2'b11);
        exp_v = crst_v;
        exp_v[31:0]    = 32'hFF34FF78;
        exp_v[63:32]   = 32'h22;
        exp_v[95:64]   = 32'h33;
        exp_v[127:96]  = 32'h44;
        exp_v[159:128] = 32'hA5A50004;
        exp_v[191:160] = 32'h5A5A0005;
        chk("ctrl_after_err_writes", ctrl, exp_v);
        chk("err_write_no_pulse", wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3] + wr_cnt[4]
                                  + wr_cnt[5] + wr_cnt[6] + wr_cnt[7], 9);
        rd(8'h40, 32'h0, 2'b11);
        rd(8'h30, 32'h0, 2'b11);
        rd(8'h20, 32'hCAFEF00D, 2'b00);
        rd(8'h2C, 32'h44440003, 2'b00);
        chk("stat_rd_pulses", {rd_cnt[0], rd_cnt[1], rd_cnt[2], rd_cnt[3]},
            {32'd1, 32'd0, 32'd0, 32'd1});

        // Backpressure on B
        axi.S_AXI_BREADY = 1'b0;
        exp_b_q.push_back(2'b00);
        fork
            aw_send(8'h18);
            w_send(32'h00000066, 4'hF);
        join
        wait_b();
        for (int i = 0; i < 10; i++) begin
            chk("b_hold", {axi.S_AXI_BVALID, axi.S_AXI_BRESP, axi.S_AXI_AWREADY, axi.S_AXI_WREADY},
                5'b1_00_00);
            @(posedge ACLK); #1;
        end
        chk("wr_state_resp", wr_state, 1);
        axi.S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;

        // Backpressure on R, with a competing AR offered
        axi.S_AXI_RREADY = 1'b0;
        exp_r_q.push_back({2'b00, 32'h00000066});
        ar_send(8'h18);
        wait_r();
        axi.S_AXI_ARADDR  = 8'h00;
        axi.S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("r_hold", {axi.S_AXI_RVALID, axi.S_AXI_RRESP, axi.S_AXI_RDATA, axi.S_AXI_ARREADY},
                {1'b1, 2'b00, 32'h00000066, 1'b0});
            @(posedge ACLK); #1;
        end
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY  = 1'b1;
        @(posedge ACLK); #1;

        // Reset while a B response is pending
        axi.S_AXI_BREADY = 1'b0;
        fork
            aw_send(8'h1C);
            w_send(32'hDEADBEEF, 4'hF);
        join
        wait_b();
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        chk("mid_rst_bvalid", axi.S_AXI_BVALID, 0);
        chk("mid_rst_ctrl", ctrl, crst_v);
        chk("mid_rst_awready", axi.S_AXI_AWREADY, 0);
        ARESET = 1'b0;
        axi.S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        chk("post_mid_rst_awready", axi.S_AXI_AWREADY, 1);
        rd(8'h1C, 32'hC0DE0007, 2'b00);
        rd(8'h18, 32'hC0DE0006, 2'b00);

        repeat (3) @(posedge ACLK); #1;
        chk("queues_drained", exp_b_q.size() + exp_r_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
